rr_arbiter: RTL
===============

# rr_arbiter

Round-robin arbiter that shares one downstream resource (bus, encoder datapath, memory port) between up to eight requesters. Each cycle in which the resource is free, it selects the first active request at or after a rotating pointer using a masked priority-encode stage. It holds the grant until the owner releases, then advances the pointer past the owner. The result is starvation-free access for the block's clients.

## Interface
- N, 8, number of requesters (2..8)
- IDW, 3, width of grant index, equals clog2(N)
- MAX_HOLD, 16, grant timeout in cycles (used only when the timeout feature is compiled in; minimum 2)

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N  request vector, bit i = requester i wants the resource; level, held until granted and done
- done  in  1  owner finished; single-cycle pulse, meaningful only while gnt_valid=1
- gnt  out  N  one-hot grant vector, all zero when idle
- gnt_id  out  IDW  binary index of the current owner; 0 when idle
- gnt_valid  out  1  a grant is active
- timeout  out  1  one-cycle pulse on a forced release; constant 0 when the feature is compiled out

## Operation
- Reset value of every output is 0. Internal rotating pointer ptr=0, state IDLE, hold counter 0.
- Two states:
  - IDLE: if |req, compute the masked pick:
    - Form the set of requests at index ≥ ptr.
    - If that set is non-empty, pick its lowest index.
    - Otherwise pick the lowest index of the full req vector (wrap-around).
    - Register gnt=onehot(pick), gnt_id=pick, gnt_valid=1, then go to GRANT.
    - If req==0, stay in IDLE with outputs 0.
  - GRANT: outputs are held stable. A release occurs when any of the following is true:
    - done=1;
    - req[gnt_id]=0 (owner abandoned the request);
    - the hold limit is hit (timeout feature only).
- On release:
  - gnt, gnt_id and gnt_valid are cleared.
  - ptr is set to gnt_id+1, wrapping N-1→0.
  - State returns to IDLE.
- done and owner req drop in the same cycle count as a single release.
- done while in IDLE is ignored.
- Requests from non-owners never disturb an active grant.
- No grant is ever issued to an index whose req bit is 0 in the sampling cycle.
- Inputs at bit positions ≥ N are ignored.

## Timing
- Request-to-grant latency: req sampled at edge k gives gnt visible after edge k (registered), i.e. 1 cycle.
- Release-to-regrant: done sampled at edge k clears gnt after edge k. The next arbitration happens at edge k+1, so there is exactly one idle cycle between consecutive grants.
- Under continuous full load (req=all ones), each requester is served once per N grants in order ptr, ptr+1, …
- Reset asserted mid-grant: all outputs, ptr and counter return to 0 after that edge. This has priority over every other event.

## Configuration
- RR_ARB_TIMEOUT_EN defined:
  - An IDW+ bit-sized hold counter (clog2(MAX_HOLD) bits) clears on grant and increments each GRANT cycle.
  - When it reaches MAX_HOLD-1 without a release, the grant is force-released next edge with the normal pointer advance, and timeout=1 for that one cycle.
  - A regular release in the same cycle takes precedence; timeout stays 0.
- RR_ARB_TIMEOUT_EN undefined:
  - No counter is present, timeout is tied to 0, and a grant is held indefinitely.

## Structure
- Shared package arb_pkg:
  - state enum (ARB_IDLE, ARB_GRANT);
  - default constants ARB_N=8, ARB_IDW=3, ARB_MAX_HOLD=16;
  - onehot-from-index helper function.
- One sub-module, rr_prio_enc: purely combinational.
  - Inputs: N-bit req and IDW-bit ptr.
  - Outputs: any (1 bit) and pick (IDW bits).
  - Internally it runs a low-index-first priority encode on the masked vector and on the full vector, and muxes between them.
- rr_arbiter holds the state register, ptr, output registers and the optional counter.

## Test plan
- Reset then idle:
  - Hold rst for 2 cycles with req=8'hFF, then release rst with req=0.
  - Required: gnt=0, gnt_id=0, gnt_valid=0, timeout=0 throughout.
- Single requester:
  - req=8'h10 at edge k.
  - Required: gnt=8'h10, gnt_id=4 after edge k.
  - Pulse done at k+3: gnt=0 after k+3, and the next pick starts at index 5.
- Full-load rotation:
  - req=8'hFF held, done pulsed on every GRANT cycle.
  - Required grant order 0,1,…,7,0 with exactly one idle cycle between grants.
- Wrap search:
  - After a grant to 6 is released (ptr=7), set req=8'h05.
  - Required: gnt_id=0 next, then 2.
- Owner abandon and simultaneous events:
  - Owner 3 drops req while done=1 in the same cycle.
  - Required: one release only, ptr=4, and no spurious second clear.
  - Also assert rst while granted: outputs return to 0 after that edge.
- Timeout (RR_ARB_TIMEOUT_EN, MAX_HOLD=16):
  - Owner 1 holds req with no done.
  - Required: timeout=1 exactly on the 16th GRANT cycle and the grant cleared.
  - With the macro undefined, the grant persists for 100 cycles and timeout stays 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared state type, default sizes and one-hot helper for the round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  localparam int ARB_N        = 8;
  localparam int ARB_IDW      = 3;
  localparam int ARB_MAX_HOLD = 16;

  function automatic logic [ARB_N-1:0] arb_onehot(input logic [ARB_IDW-1:0] idx);
    logic [ARB_N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating-priority pick: lowest active request at or after ptr, else lowest overall.
module rr_prio_enc
  import arb_pkg::*;
#(
  parameter int N   = ARB_N,
  parameter int IDW = ARB_IDW
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] pick
);

  logic [N-1:0]   masked;
  logic [IDW-1:0] maskedPick;
  logic [IDW-1:0] fullPick;

  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) begin
      masked[i] = req[i] && (i >= int'(ptr));
    end
  end

  // Scanning downward lets the lowest set index overwrite any higher one.
  always_comb begin
    maskedPick = '0;
    fullPick   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (masked[i]) maskedPick = IDW'(i);
      if (req[i])    fullPick   = IDW'(i);
    end
  end

  assign any  = |req;
  assign pick = (|masked) ? maskedPick : fullPick;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant hold until release.
// Optional forced release after MAX_HOLD cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDW      = ARB_IDW,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("rr_arbiter: MAX_HOLD must be at least 2");
  end
  if (IDW != $clog2(N)) begin : g_bad_idw
    $error("rr_arbiter: IDW must equal clog2(N)");
  end

  arb_state_t     state;
  logic [IDW-1:0] ptr;
  logic           pickAny;
  logic [IDW-1:0] pick;
  logic [ARB_N-1:0] pickOh;
  logic           release_;
  logic           forced;

  rr_prio_enc #(.N(N), .IDW(IDW)) u_enc (
    .req  (req),
    .ptr  (ptr),
    .any  (pickAny),
    .pick (pick)
  );

  assign pickOh   = arb_onehot(ARB_IDW'(pick));
  assign release_ = done || !req[gnt_id];

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] holdCnt;

  assign forced = (holdCnt == HW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst || state == ARB_IDLE) begin
      holdCnt <= '0;
    end else if (!release_ && !forced) begin
      holdCnt <= holdCnt + HW'(1);
    end
  end
`else
  assign forced = 1'b0;
`endif

  // A regular release outranks a forced one, so timeout only flags the pure forced case.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pickAny) begin
            gnt       <= pickOh[N-1:0];
            gnt_id    <= pick;
            gnt_valid <= 1'b1;
            state     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (release_ || forced) begin
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            ptr       <= (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);
            timeout   <= forced && !release_;
            state     <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
